// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states, port owner and the
// default starvation limit.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } mem_owner_t;

    localparam int unsigned ARB_STARVE_MAX_DEF = 4;
    localparam int unsigned STARVE_CNT_W       = 4;

    // True once the counter has reached the limit while fetch is still waiting.
    function automatic logic starve_hit(input logic [STARVE_CNT_W-1:0] cnt,
                                        input logic [STARVE_CNT_W-1:0] lim,
                                        input logic                    if_elig);
        return if_elig && (cnt == lim);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the shared memory port: data side wins by default,
// fetch is forced through after STARVE_MAX consecutive data wins.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = ARB_STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic if_elig,
    input  logic d_req,
    input  logic grant_en,
    output logic grant_i,
    output logic grant_d
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] starve_cnt_r;
    logic                    starved_s;

    // Combinational winner selection, only meaningful while the port is idle.
    always_comb begin
        starved_s = starve_hit(starve_cnt_r, STARVE_LIM, if_elig);
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        if (grant_en) begin
            if (d_req && !starved_s) begin
                grant_d = 1'b1;
            end else if (if_elig) begin
                grant_i = 1'b1;
            end else begin
                grant_i = 1'b0;
                grant_d = 1'b0;
            end
        end else begin
            grant_i = 1'b0;
            grant_d = 1'b0;
        end
    end

    // Starvation counter: counts data wins that bypassed an eligible fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= {STARVE_CNT_W{1'b0}};
        end else if (!if_req || grant_i) begin
            starve_cnt_r <= {STARVE_CNT_W{1'b0}};
        end else if (grant_d && if_elig && (starve_cnt_r != STARVE_LIM)) begin
            starve_cnt_r <= starve_cnt_r + {{(STARVE_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// outstanding transaction at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = ARB_STARVE_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_kill,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_valid,
    output logic                  m_req,
    output logic                  m_we,
    output logic [DATA_W/8-1:0]   m_be,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_gnt,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_t state_r;
    mem_owner_t owner_r;
    logic       killed_r;
    logic       if_elig_s;
    logic       grant_en_s;
    logic       grant_i_s;
    logic       grant_d_s;
    logic       complete_s;
    logic       kill_hit_s;

    assign if_elig_s  = if_req && !if_kill;
    assign grant_en_s = (state_r == ARB_IDLE);
    assign kill_hit_s = if_kill && (owner_r == OWN_I);

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_elig  (if_elig_s),
        .d_req    (d_req),
        .grant_en (grant_en_s),
        .grant_i  (grant_i_s),
        .grant_d  (grant_d_s)
    );

    // Completion detect: stray rvalid in IDLE, or without gnt in ISSUE, is dropped.
    always_comb begin
        complete_s = 1'b0;
        case (state_r)
            ARB_ISSUE: complete_s = m_gnt && m_rvalid;
            ARB_WAIT:  complete_s = m_rvalid;
            default:   complete_s = 1'b0;
        endcase
    end

    // Response steering; a fetch killed in flight is absorbed silently.
    always_comb begin
        if_rdata = m_rdata;
        d_rdata  = m_rdata;
        if (complete_s && (owner_r == OWN_D)) begin
            d_valid  = 1'b1;
            if_valid = 1'b0;
        end else if (complete_s && (owner_r == OWN_I)) begin
            d_valid  = 1'b0;
            if_valid = !killed_r && !if_kill;
        end else begin
            d_valid  = 1'b0;
            if_valid = 1'b0;
        end
    end

    // Transaction FSM with registered memory-side request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ARB_IDLE;
            owner_r  <= OWN_I;
            killed_r <= 1'b0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_be     <= {BE_W{1'b0}};
            m_addr   <= {ADDR_W{1'b0}};
            m_wdata  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    killed_r <= 1'b0;
                    if (grant_d_s) begin
                        owner_r <= OWN_D;
                        m_we    <= d_we;
                        m_be    <= d_be;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        m_req   <= 1'b1;
                        state_r <= ARB_ISSUE;
                    end else if (grant_i_s) begin
                        owner_r <= OWN_I;
                        m_we    <= 1'b0;
                        m_be    <= {BE_W{1'b1}};
                        m_addr  <= if_addr;
                        m_wdata <= {DATA_W{1'b0}};
                        m_req   <= 1'b1;
                        state_r <= ARB_ISSUE;
                    end else begin
                        m_req   <= 1'b0;
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_ISSUE: begin
                    if (m_gnt && m_rvalid) begin
                        m_req    <= 1'b0;
                        killed_r <= 1'b0;
                        state_r  <= ARB_IDLE;
                    end else if (m_gnt) begin
                        m_req    <= 1'b0;
                        killed_r <= killed_r || kill_hit_s;
                        state_r  <= ARB_WAIT;
                    end else begin
                        killed_r <= killed_r || kill_hit_s;
                        state_r  <= ARB_ISSUE;
                    end
                end
                ARB_WAIT: begin
                    if (m_rvalid) begin
                        killed_r <= 1'b0;
                        state_r  <= ARB_IDLE;
                    end else begin
                        killed_r <= killed_r || kill_hit_s;
                        state_r  <= ARB_WAIT;
                    end
                end
                default: begin
                    m_req    <= 1'b0;
                    killed_r <= 1'b0;
                    state_r  <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: inputs change 1 ns after
// the rising edge, outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    int chk_cnt;
    int pass_cnt;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_kill  (if_kill),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; memory responses default low.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
    endtask

    initial begin
        logic exp_i;
        chk_cnt  = 0;
        pass_cnt = 0;
        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        if_kill  = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_be     = 4'h0;
        d_addr   = 32'h0;
        d_wdata  = 32'h0;
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_m_req",   {31'd0, m_req}, 32'd0);
        check_eq("rst_m_we",    {31'd0, m_we}, 32'd0);
        check_eq("rst_m_be",    {28'd0, m_be}, 32'd0);
        check_eq("rst_m_addr",  m_addr, 32'h0);
        check_eq("rst_m_wdata", m_wdata, 32'h0);
        check_eq("rst_if_valid",{31'd0, if_valid}, 32'd0);
        check_eq("rst_d_valid", {31'd0, d_valid}, 32'd0);

        // Fetch alone: gnt in cycle 1, rvalid in cycle 3.
        next_cycle();
        if_req  = 1'b1;
        if_addr = 32'h100;
        @(negedge clk);
        check_eq("f_c0_m_req", {31'd0, m_req}, 32'd0);
        next_cycle();
        m_gnt = 1'b1;
        @(negedge clk);
        check_eq("f_c1_m_req",  {31'd0, m_req}, 32'd1);
        check_eq("f_c1_m_addr", m_addr, 32'h100);
        check_eq("f_c1_m_be",   {28'd0, m_be}, 32'hF);
        check_eq("f_c1_m_we",   {31'd0, m_we}, 32'd0);
        check_eq("f_c1_ifv",    {31'd0, if_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        check_eq("f_c2_m_req", {31'd0, m_req}, 32'd0);
        check_eq("f_c2_ifv",   {31'd0, if_valid}, 32'd0);
        next_cycle();
        m_rvalid = 1'b1;
        m_rdata  = 32'h00500093;
        @(negedge clk);
        check_eq("f_c3_ifv",   {31'd0, if_valid}, 32'd1);
        check_eq("f_c3_rdata", if_rdata, 32'h00500093);
        check_eq("f_c3_dv",    {31'd0, d_valid}, 32'd0);
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        check_eq("f_c4_ifv",   {31'd0, if_valid}, 32'd0);
        check_eq("f_c4_m_req", {31'd0, m_req}, 32'd0);

        // Simultaneous store and fetch: data first, fetch in the next IDLE cycle.
        next_cycle();
        if_req  = 1'b1;
        if_addr = 32'h200;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h2000;
        d_wdata = 32'hDEADBEEF;
        d_be    = 4'h3;
        @(negedge clk);
        check_eq("s_idle_m_req", {31'd0, m_req}, 32'd0);
        next_cycle();
        m_gnt    = 1'b1;
        m_rvalid = 1'b1;
        @(negedge clk);
        check_eq("s_d_m_we",    {31'd0, m_we}, 32'd1);
        check_eq("s_d_m_be",    {28'd0, m_be}, 32'h3);
        check_eq("s_d_m_addr",  m_addr, 32'h2000);
        check_eq("s_d_m_wdata", m_wdata, 32'hDEADBEEF);
        check_eq("s_d_dv",      {31'd0, d_valid}, 32'd1);
        check_eq("s_d_ifv",     {31'd0, if_valid}, 32'd0);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        check_eq("s_gap_m_req", {31'd0, m_req}, 32'd0);
        next_cycle();
        m_gnt    = 1'b1;
        m_rvalid = 1'b1;
        m_rdata  = 32'h11112222;
        @(negedge clk);
        check_eq("s_i_m_addr", m_addr, 32'h200);
        check_eq("s_i_m_we",   {31'd0, m_we}, 32'd0);
        check_eq("s_i_m_be",   {28'd0, m_be}, 32'hF);
        check_eq("s_i_ifv",    {31'd0, if_valid}, 32'd1);
        check_eq("s_i_rdata",  if_rdata, 32'h11112222);
        check_eq("s_i_dv",     {31'd0, d_valid}, 32'd0);
        next_cycle();
        if_req = 1'b0;

        // Starvation with zero-wait memory: D,D,D,D,I,D,D,D,D,I.
        next_cycle();
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_be    = 4'hF;
        d_addr  = 32'h3000;
        d_wdata = 32'h0;
        if_req  = 1'b1;
        if_addr = 32'h300;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("st_idle_m_req", {31'd0, m_req}, 32'd0);
            next_cycle();
            m_gnt    = 1'b1;
            m_rvalid = 1'b1;
            m_rdata  = 32'hA0000000 + 32'(k);
            exp_i    = (k == 4) || (k == 9);
            @(negedge clk);
            check_eq("st_m_req",  {31'd0, m_req}, 32'd1);
            check_eq("st_m_addr", m_addr, exp_i ? 32'h300 : 32'h3000);
            check_eq("st_ifv",    {31'd0, if_valid}, {31'd0, exp_i});
            check_eq("st_dv",     {31'd0, d_valid}, {31'd0, !exp_i});
            check_eq("st_rdata",  exp_i ? if_rdata : d_rdata, 32'hA0000000 + 32'(k));
            next_cycle();
        end
        d_req  = 1'b0;
        if_req = 1'b0;

        // Kill while the fetch waits for its response; the next fetch is normal.
        next_cycle();
        if_req  = 1'b1;
        if_addr = 32'h40;
        next_cycle();
        m_gnt = 1'b1;
        @(negedge clk);
        check_eq("k_m_addr", m_addr, 32'h40);
        next_cycle();
        if_kill = 1'b1;
        if_addr = 32'h80;
        @(negedge clk);
        check_eq("k_kill_ifv", {31'd0, if_valid}, 32'd0);
        next_cycle();
        if_kill  = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'hBAD0BAD0;
        @(negedge clk);
        check_eq("k_absorb_ifv", {31'd0, if_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        check_eq("k_idle_m_req", {31'd0, m_req}, 32'd0);
        next_cycle();
        m_gnt    = 1'b1;
        m_rvalid = 1'b1;
        m_rdata  = 32'h00000080;
        @(negedge clk);
        check_eq("k_new_m_addr", m_addr, 32'h80);
        check_eq("k_new_ifv",    {31'd0, if_valid}, 32'd1);
        check_eq("k_new_rdata",  if_rdata, 32'h00000080);
        next_cycle();
        if_req = 1'b0;

        // Async reset while a store waits; a stale rvalid arrives with it.
        next_cycle();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'hF;
        d_addr  = 32'h500;
        d_wdata = 32'h55;
        next_cycle();
        m_gnt = 1'b1;
        @(negedge clk);
        check_eq("r_issue_m_req", {31'd0, m_req}, 32'd1);
        next_cycle();
        m_rvalid = 1'b1;
        m_rdata  = 32'h00000BAD;
        reset    = 1'b1;
        d_req    = 1'b0;
        #1;
        check_eq("r_async_m_req",  {31'd0, m_req}, 32'd0);
        check_eq("r_async_m_addr", m_addr, 32'h0);
        check_eq("r_async_m_we",   {31'd0, m_we}, 32'd0);
        check_eq("r_async_dv",     {31'd0, d_valid}, 32'd0);
        check_eq("r_async_ifv",    {31'd0, if_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
        m_rvalid = 1'b1;
        m_rdata  = 32'h00000BAD;
        @(negedge clk);
        check_eq("r_stale_dv", {31'd0, d_valid}, 32'd0);
        next_cycle();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h600;
        @(negedge clk);
        check_eq("r_idle_m_req", {31'd0, m_req}, 32'd0);
        next_cycle();
        m_gnt = 1'b1;
        @(negedge clk);
        check_eq("r_new_m_req",  {31'd0, m_req}, 32'd1);
        check_eq("r_new_m_addr", m_addr, 32'h600);
        check_eq("r_new_m_we",   {31'd0, m_we}, 32'd0);
        next_cycle();
        @(negedge clk);
        check_eq("r_wait_m_req", {31'd0, m_req}, 32'd0);
        check_eq("r_wait_dv",    {31'd0, d_valid}, 32'd0);
        next_cycle();
        m_rvalid = 1'b1;
        m_rdata  = 32'h12345678;
        @(negedge clk);
        check_eq("r_new_dv",    {31'd0, d_valid}, 32'd1);
        check_eq("r_new_rdata", d_rdata, 32'h12345678);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        check_eq("r_done_dv", {31'd0, d_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory port between the fetch path (read-only) and the load/store path (read/write).
- Sits between the IF/MEM stage memory interfaces and a single memory or bus slave.
- Allows one outstanding transaction at a time.
- Data side has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; byte-enable width is DATA_W/8
STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced to win (1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held until if_valid or if_kill
if_addr  in  ADDR_W  fetch address
if_kill  in  1  fetch redirect/flush; cancels pending or in-flight fetch
if_rdata  out  DATA_W  fetch data, meaningful when if_valid
if_valid  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held with fields stable until d_valid
d_we  in  1  1 = store, 0 = load
d_be  in  DATA_W/8  byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, meaningful when d_valid
d_valid  out  1  one-cycle data completion pulse (loads and stores)
m_req  out  1  memory request, held until m_gnt
m_we / m_be / m_addr / m_wdata  out  1 / DATA_W/8 / ADDR_W / DATA_W  registered request fields
m_gnt  in  1  memory accepts request this cycle
m_rvalid  in  1  response/ack; exactly one per accepted request, any later cycle or same cycle as m_gnt
m_rdata  in  DATA_W  read data with m_rvalid

Behaviour:
- FSM states: IDLE, ISSUE, WAIT. Owner register records OWN_I or OWN_D.
- Reset values: state=IDLE, m_req=0, m_* fields=0, if_valid=0, d_valid=0, killed=0, starve_cnt=0. Reset is asynchronous, so m_req drops immediately.
- IDLE arbitration. Fetch is eligible when if_req && !if_kill.
  - d_req only: grant D.
  - Fetch only: grant I.
  - Both: grant D unless starve_cnt==STARVE_MAX, then grant I.
- On grant:
  - Capture fields into m_* (fetch: m_we=0, m_be=all ones), set owner, go to ISSUE.
  - m_req is high from the next cycle.
- ISSUE: m_req=1.
  - m_gnt && !m_rvalid: go to WAIT (m_req low).
  - m_gnt && m_rvalid: complete this cycle, go to IDLE.
- WAIT: m_req=0. On m_rvalid, complete and go to IDLE.
- Completion:
  - Owner D: d_valid=1 and d_rdata=m_rdata, combinational in the m_rvalid cycle. Stores also pulse d_valid; d_rdata is don't-care.
  - Owner I: if_valid=1 and if_rdata=m_rdata, unless killed.
- Minimum latency: request sampled in cycle 0, m_req in cycle 1, earliest completion in cycle 1 (gnt and rvalid together).
- if_kill:
  - In IDLE: fetch is not eligible that cycle.
  - While owner I in ISSUE/WAIT: set killed. The memory transaction still completes (it is never abandoned once m_req is raised), the response is absorbed with no if_valid, and killed clears on completion.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on each D grant while fetch is eligible.
  - Clears on an I grant or whenever if_req=0.
- Back-to-back: return to IDLE costs one cycle. A requester holding req after valid is re-arbitrated in that IDLE cycle.
- m_rvalid in IDLE, and m_rvalid without m_gnt in ISSUE, are ignored (protocol violation). A sim-only assertion flags them.
- m_gnt in IDLE or WAIT is ignored.
- Address/width: no alignment checking; addresses pass through unchanged.

Decomposition:
- cpu_types gains: typedef enum arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT}; typedef enum mem_owner_t {OWN_I, OWN_D}; localparam ARB_STARVE_MAX_DEF=4.
- One sub-module, mem_arb_pick: combinational winner selection plus the starvation counter register (clk, reset, if_elig, d_req, grant_en -> grant_i, grant_d).

Test Plan:
- Fetch alone: if_req=1, if_addr=0x100; memory gives gnt in cycle 1, rvalid in cycle 3 with 0x00500093 -> if_valid pulses once in cycle 3 with if_rdata=0x00500093; m_addr=0x100, m_be=4'hF, m_we=0.
- Simultaneous requests: if_req and d_req (store, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'h3) in the same cycle -> D issued first with m_we=1, m_be=4'h3; d_valid on ack; fetch issued in the following IDLE cycle.
- Starvation, STARVE_MAX=4: d_req held continuously with back-to-back loads, if_req=1 -> exactly 4 D grants, then 1 I grant, then D resumes; starve_cnt=0 after the I grant.
- Kill in flight: fetch to 0x40 in WAIT, if_kill pulsed for 1 cycle, then rvalid arrives -> no if_valid. The next arbitration proceeds normally with a new fetch to 0x80, which returns correct data.
- Zero-wait memory: gnt and rvalid asserted together in the first ISSUE cycle -> completion in that cycle, no WAIT state entered, next request issued 2 cycles later.
- Async reset during WAIT with owner D -> m_req and all valids 0 immediately; a stale rvalid after reset release produces no d_valid; a fresh d_req is then serviced correctly.
